// File: rtl/iterative_shift_alu_pkg.sv
// Shared definitions for the execute-stage ALU: op select codes, FSM states, width defaults.
package iterative_shift_alu_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int SHW_DEFAULT  = 5;

  // Same select encoding as the ALU control decoder.
  localparam logic [3:0] ALU_SEL_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SEL_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SEL_OR   = 4'b0100;
  localparam logic [3:0] ALU_SEL_AND  = 4'b0101;
  localparam logic [3:0] ALU_SEL_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SEL_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SEL_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SEL_SRA  = 4'b1010;
  localparam logic [3:0] ALU_SEL_SLT  = 4'b1101;
  localparam logic [3:0] ALU_SEL_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SEL_SLL) || (sel == ALU_SEL_SRL) || (sel == ALU_SEL_SRA);
  endfunction

endpackage

// File: rtl/iterative_shift_alu_if.sv
// Handshake and data bundle between ID/EX, the ALU and the downstream stage.
interface iterative_shift_alu_if #(parameter int XLEN = 32);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_sel;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  modport master (
    output flush, in_valid, alu_sel, a, b, out_ready,
    input  in_ready, out_valid, result, zero, busy
  );

  modport slave (
    input  flush, in_valid, alu_sel, a, b, out_ready,
    output in_ready, out_valid, result, zero, busy
  );
endinterface

// File: rtl/iterative_shift_alu_comb_core.sv
// Purely combinational evaluator for the single-cycle ops; unlisted codes behave as ADD.
module alu_comb_core
  import iterative_shift_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      sel_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] y_o
);

  always_comb begin
    y_o = a_i + b_i;
    unique case (sel_i)
      ALU_SEL_SUB:  y_o = a_i - b_i;
      ALU_SEL_OR:   y_o = a_i | b_i;
      ALU_SEL_AND:  y_o = a_i & b_i;
      ALU_SEL_XOR:  y_o = a_i ^ b_i;
      ALU_SEL_SLT:  y_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SEL_SLTU: y_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default:      y_o = a_i + b_i;
    endcase
  end

endmodule

// File: rtl/iterative_shift_alu.sv
// Execute-stage ALU: 1-cycle logic/arith ops, shifts iterated one bit per cycle.
module iterative_shift_alu
  import iterative_shift_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int SHW  = SHW_DEFAULT
) (
  input logic                  clk,
  input logic                  rst_n,
  iterative_shift_alu_if.slave bus
);

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [3:0]      op_q, op_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [XLEN-1:0] core_y;
  logic            in_ready;
  logic            accept;
  logic [SHW-1:0]  shamt;

  alu_comb_core #(.XLEN(XLEN)) u_core (
    .sel_i (bus.alu_sel),
    .a_i   (bus.a),
    .b_i   (bus.b),
    .y_o   (core_y)
  );

  assign shamt    = bus.b[SHW-1:0];
  assign in_ready = !bus.flush &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    result_d = result_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      if (is_shift(bus.alu_sel) && (shamt != '0)) begin
        state_d  = ST_SHIFT;
        result_d = bus.a;
        cnt_d    = shamt;
        op_d     = bus.alu_sel;
      end else begin
        state_d  = ST_DONE;
        result_d = is_shift(bus.alu_sel) ? bus.a : core_y;
      end
    end else begin
      unique case (state_q)
        ST_SHIFT: begin
          // result_q doubles as the shift working register; SRA keeps its MSB.
          unique case (op_q)
            ALU_SEL_SLL: result_d = {result_q[XLEN-2:0], 1'b0};
            ALU_SEL_SRL: result_d = {1'b0, result_q[XLEN-1:1]};
            default:     result_d = {result_q[XLEN-1], result_q[XLEN-1:1]};
          endcase
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) state_d = ST_DONE;
        end
        ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= ALU_SEL_ADD;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iterative_shift_alu.sv
// Directed self-checking bench for iterative_shift_alu.
module tb_iterative_shift_alu;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  iterative_shift_alu_if #(.XLEN(32)) bus ();

  iterative_shift_alu #(.XLEN(32), .SHW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.alu_sel  = sel;
    bus.a        = a;
    bus.b        = b;
  endtask

  // Called one negedge after the accept edge; lat = cycles until out_valid, -1 on timeout.
  task automatic wait_valid(input int max, output int lat);
    lat = -1;
    for (int k = 1; k <= max; k++) begin
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
    n_tests++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %0b want 1", bus.zero); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid_shift;
    logic seen_valid;
    seen_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'b1000, 32'h1, 32'd20);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) begin
      if (bus.out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL midrst_result got %h want 0", bus.result); end
    n_tests++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL midrst_zero got %0b want 1", bus.zero); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %0b want 1", bus.in_ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %0b want 0", bus.busy); end
    repeat (25) begin
      if (bus.out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output got out_valid=%0b want 0", seen_valid); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  sels [4] = '{4'b0000, 4'b0001, 4'b1101, 4'b1111};
    logic [31:0] as   [4] = '{32'd7, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs   [4] = '{32'd5, 32'd7, 32'd1, 32'd1};
    logic [31:0] exps [4] = '{32'd12, 32'hFFFF_FFFE, 32'd1, 32'd0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %0b want 1", i, bus.in_ready); end
      drive(sels[i], as[i], bs[i]);
      @(negedge clk);
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %0b want 1", i, bus.out_valid); end
      n_tests++; if (bus.result !== exps[i]) begin n_fail++; $display("FAIL b2b_result[%0d] got %h want %h", i, bus.result, exps[i]); end
    end
    n_tests++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL b2b_zero_sltu got %0b want 1", bus.zero); end
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_sra;
    int lat;
    int bad_busy;
    int bad_rdy;
    bad_busy = 0;
    bad_rdy  = 0;
    bus.out_ready = 1'b1;
    drive(4'b1010, 32'h8000_0000, 32'd31);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 32'h0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (bus.busy !== 1'b1) bad_busy++;
      if (bus.in_ready !== 1'b0) bad_rdy++;
      @(negedge clk);
    end
    n_tests++; if (lat !== 32) begin n_fail++; $display("FAIL sra_latency got %0d want 32", lat); end
    n_tests++; if (bus.result !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra_result got %h want ffffffff", bus.result); end
    n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL sra_busy_done got %0b want 1", bus.busy); end
    n_tests++; if (bad_busy !== 0) begin n_fail++; $display("FAIL sra_busy_shift got %0d low cycles want 0", bad_busy); end
    n_tests++; if (bad_rdy !== 0) begin n_fail++; $display("FAIL sra_in_ready_shift got %0d high cycles want 0", bad_rdy); end
    @(negedge clk);
  endtask

  task automatic test_shifts_short;
    int lat;
    bus.out_ready = 1'b1;
    drive(4'b1001, 32'h0000_1234, 32'h20);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL shz_latency got valid=%0b want 1", bus.out_valid); end
    n_tests++; if (bus.result !== 32'h0000_1234) begin n_fail++; $display("FAIL shz_result got %h want 00001234", bus.result); end
    n_tests++; if (bus.zero !== 1'b0) begin n_fail++; $display("FAIL shz_zero got %0b want 0", bus.zero); end
    @(negedge clk);
    drive(4'b1001, 32'h8000_0000, 32'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(10, lat);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL srl4_latency got %0d want 5", lat); end
    n_tests++; if (bus.result !== 32'h0800_0000) begin n_fail++; $display("FAIL srl4_result got %h want 08000000", bus.result); end
    @(negedge clk);
    drive(4'b1000, 32'h0000_0003, 32'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(10, lat);
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL sll4_latency got %0d want 5", lat); end
    n_tests++; if (bus.result !== 32'h0000_0030) begin n_fail++; $display("FAIL sll4_result got %h want 00000030", bus.result); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    bus.out_ready = 1'b0;
    drive(4'b0111, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    @(negedge clk);
    drive(4'b0000, 32'd1, 32'd1);
    for (int c = 0; c < 4; c++) begin
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %0b want 1", c, bus.out_valid); end
      n_tests++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL bp_result[%0d] got %h want 0", c, bus.result); end
      n_tests++; if (bus.zero !== 1'b1) begin n_fail++; $display("FAIL bp_zero[%0d] got %0b want 1", c, bus.zero); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %0b want 0", c, bus.in_ready); end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", bus.in_ready); end
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", bus.out_valid); end
  endtask

  task automatic test_flush;
    logic seen_valid;
    seen_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'b1000, 32'h1, 32'd10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.flush = 1'b1;
    drive(4'b0000, 32'd9, 32'd9);
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got %0b want 0", bus.in_ready); end
    @(negedge clk);
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %0b want 0", bus.busy); end
    repeat (15) begin
      if (bus.out_valid) seen_valid = 1'b1;
      @(negedge clk);
    end
    n_tests++; if (seen_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_output got %0b want 0", seen_valid); end
    drive(4'b0000, 32'd2, 32'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL flush_add_valid got %0b want 1", bus.out_valid); end
    n_tests++; if (bus.result !== 32'd4) begin n_fail++; $display("FAIL flush_add_result got %h want 4", bus.result); end
    @(negedge clk);
  endtask

  task automatic test_unknown_code;
    bus.out_ready = 1'b1;
    drive(4'b0110, 32'd3, 32'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL unk_valid got %0b want 1", bus.out_valid); end
    n_tests++; if (bus.result !== 32'd7) begin n_fail++; $display("FAIL unk_result got %h want 7", bus.result); end
    @(negedge clk);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alu_sel   = 4'b0000;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_reset_mid_shift();
    test_back_to_back();
    test_sra();
    test_shifts_short();
    test_backpressure();
    test_flush();
    test_unknown_code();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
